score_bcd_feeder: RTL and testbench
===================================

SCORE_BCD_FEEDER -- requirements
Module: score_bcd_feeder

Interface
REQ-001 Parameter BLINK_DIV, default 25000000: cycles per flash toggle while game over.
REQ-002 Parameter REFRESH_DIV, default 1000000: idle cycles between periodic Start re-shifts.
REQ-003 Parameter LES_MASK, default 8'h0F: digits enabled for flashing in game over.
REQ-004 Parameter POINT_MASK, default 8'hFF: constant decimal-point pattern (all off).
REQ-005 clk  in  1  system clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 score  in  14  binary current score.
REQ-008 score_vld  in  1  one-cycle pulse; score valid.
REQ-009 game_over  in  1  level; high enables blinking.
REQ-010 Hexs  out  32  BCD digits; [31:16] best score, [15:0] current score.
REQ-011 point  out  8  decimal points, equals POINT_MASK.
REQ-012 LES  out  8  per-digit flash enable.
REQ-013 flash  out  1  blink phase.
REQ-014 Start  out  1  one-cycle pulse; serializer load/shift request.
REQ-015 busy  out  1  high while not in IDLE.

Function
REQ-016 FSM states SHALL be IDLE, CONV_S, CONV_B, LOAD, START.
REQ-017 IDLE, score_vld=1 (or pending set): capture clamp(score) into work reg, best <= max(best, clamp(score)), go CONV_S; counter=0.
REQ-018 clamp(x) SHALL be min(x, 9999).
REQ-019 CONV_S: one shift-add-3 (double-dabble) step per cycle, 14 cycles, 16-bit BCD result held; then CONV_B.
REQ-020 CONV_B: same conversion on best, 14 cycles; then LOAD.
REQ-021 LOAD: Hexs <= {best_bcd, score_bcd} in one cycle; then START.
REQ-022 START: Start=1 for exactly that cycle; then IDLE.
REQ-023 Latency: score_vld sampled at edge N -> Hexs updated at edge N+29 -> Start high during cycle after edge N+30 ... i.e. Start high between edges N+30 and N+31; busy high from edge N through edge N+30.
REQ-024 score_vld while busy SHALL store score in a pending reg (last value wins) and set pending flag; no abort of current conversion.
REQ-025 IDLE with pending set SHALL start conversion of pending value next cycle, clear pending flag; new score_vld in the same cycle overrides pending.
REQ-026 Refresh counter SHALL count only in IDLE; at REFRESH_DIV-1 it issues Start for one cycle (Hexs unchanged) and resets to 0.
REQ-027 Refresh tick coinciding with score_vld or pending: conversion wins, refresh dropped, counter reset to 0.
REQ-028 Refresh counter SHALL reset to 0 whenever FSM leaves IDLE.
REQ-029 game_over=1: blink counter counts; flash toggles every BLINK_DIV cycles; LES=LES_MASK.
REQ-030 game_over=0: blink counter=0, flash=0, LES=8'h00 within one cycle.
REQ-031 point SHALL equal POINT_MASK at all times, including reset.
REQ-032 Start SHALL never be high in two consecutive cycles.

Reset
REQ-033 rst=0 SHALL asynchronously force: FSM IDLE, Hexs=0, best=0, pending=0, Start=0, flash=0, LES=0, busy=0, all counters 0.
REQ-034 Reset mid-conversion SHALL discard work, pending and best; no Start issued after release until next event.
REQ-035 Input score_vld during first cycle after rst release SHALL be accepted normally.

Verification
REQ-036 After reset, score=1234 pulse -> 29 edges later Hexs=32'h12341234, next cycle Start=1 one cycle, busy low after.
REQ-037 Then score=56 -> Hexs=32'h12340056 (best held); then score=2000 -> Hexs=32'h20002000.
REQ-038 score=12000 -> Hexs=32'h99999999 (clamp applies to both fields).
REQ-039 score=10, then 20 and 30 while busy -> exactly two conversions, final Hexs=32'h00300030, two Start pulses total.
REQ-040 BLINK_DIV=4, game_over=1 -> flash toggles every 4 cycles, LES=8'h0F; game_over=0 -> flash=0, LES=0 next cycle.
REQ-041 REFRESH_DIV=8 idle -> Start every 8 cycles, Hexs constant; rst=0 at cycle 10 of conversion -> all outputs 0 immediately, no Start after release.

Source files
------------

// File: rtl/score_bcd_feeder.sv
// Score display feeder: clamps binary scores, converts current and best score to BCD
// by double-dabble, loads the display word and requests a serializer shift.
module score_bcd_feeder #(
    parameter int          BLINK_DIV   = 25000000,
    parameter int          REFRESH_DIV = 1000000,
    parameter logic [7:0]  LES_MASK    = 8'h0F,
    parameter logic [7:0]  POINT_MASK  = 8'hFF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [13:0] score_i,
    input  logic        score_vld_i,
    input  logic        game_over_i,
    output logic [31:0] hexs_o,
    output logic [7:0]  point_o,
    output logic [7:0]  les_o,
    output logic        flash_o,
    output logic        start_o,
    output logic        busy_o
);

    // state  | meaning
    // IDLE   | waiting for a score or refresh tick
    // CONV_S | double-dabble of current score, 14 steps
    // CONV_B | double-dabble of best score, 14 steps
    // LOAD   | latch both BCD results into the display word
    // START  | one-cycle serializer request
    typedef enum logic [2:0] {IDLE, CONV_S, CONV_B, LOAD, START} state_t;

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    state_t        state_q;
    logic [29:0]   work_q;
    logic [3:0]    step_q;
    logic [13:0]   best_q;
    logic [13:0]   pend_val_q;
    logic          pend_q;
    logic [15:0]   score_bcd_q;
    logic [15:0]   best_bcd_q;
    logic [31:0]   hexs_q;
    logic          start_q;
    logic          busy_q;
    logic [RW-1:0] refresh_q;
    logic [BW-1:0] blink_q;
    logic          flash_q;
    logic [7:0]    les_q;

    logic [13:0]   score_clamp_d;
    logic          take_d;
    logic [13:0]   take_val_d;
    logic [29:0]   work_d;

    function automatic logic [13:0] clamp_score(input logic [13:0] x);
        return (x > 14'd9999) ? 14'd9999 : x;
    endfunction

    // One add-3-then-shift step over {bcd[15:0], bin[13:0]}.
    function automatic logic [29:0] dd_step(input logic [29:0] w);
        logic [15:0] b;
        b = w[29:14];
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5) b[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return {b, w[13:0]} << 1;
    endfunction

    always_comb begin
        score_clamp_d = clamp_score(score_i);
        take_d        = score_vld_i || pend_q;
        take_val_d    = score_vld_i ? score_clamp_d : pend_val_q;
        work_d        = dd_step(work_q);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            work_q      <= '0;
            step_q      <= '0;
            best_q      <= '0;
            pend_val_q  <= '0;
            pend_q      <= 1'b0;
            score_bcd_q <= '0;
            best_bcd_q  <= '0;
            hexs_q      <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            refresh_q   <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take_d) begin
                        work_q    <= {16'd0, take_val_d};
                        best_q    <= (take_val_d > best_q) ? take_val_d : best_q;
                        pend_q    <= 1'b0;
                        step_q    <= '0;
                        refresh_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= CONV_S;
                    end else if (refresh_q == REFRESH_LAST) begin
                        refresh_q <= '0;
                        // never back-to-back with the conversion's own Start
                        start_q   <= ~start_q;
                    end else begin
                        refresh_q <= refresh_q + 1'b1;
                    end
                end
                CONV_S: begin
                    if (step_q == 4'd13) begin
                        score_bcd_q <= work_d[29:14];
                        work_q      <= {16'd0, best_q};
                        step_q      <= '0;
                        state_q     <= CONV_B;
                    end else begin
                        work_q <= work_d;
                        step_q <= step_q + 1'b1;
                    end
                end
                CONV_B: begin
                    if (step_q == 4'd13) begin
                        best_bcd_q <= work_d[29:14];
                        step_q     <= '0;
                        state_q    <= LOAD;
                    end else begin
                        work_q <= work_d;
                        step_q <= step_q + 1'b1;
                    end
                end
                LOAD: begin
                    hexs_q  <= {best_bcd_q, score_bcd_q};
                    state_q <= START;
                end
                START: begin
                    start_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
            // Scores arriving mid-conversion are parked; the newest one wins.
            if (state_q != IDLE && score_vld_i) begin
                pend_q     <= 1'b1;
                pend_val_q <= score_clamp_d;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            blink_q <= '0;
            flash_q <= 1'b0;
            les_q   <= '0;
        end else if (!game_over_i) begin
            blink_q <= '0;
            flash_q <= 1'b0;
            les_q   <= '0;
        end else begin
            les_q <= LES_MASK;
            if (blink_q == BLINK_LAST) begin
                blink_q <= '0;
                flash_q <= ~flash_q;
            end else begin
                blink_q <= blink_q + 1'b1;
            end
        end
    end

    assign hexs_o  = hexs_q;
    assign point_o = POINT_MASK;
    assign les_o   = les_q;
    assign flash_o = flash_q;
    assign start_o = start_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_score_bcd_feeder.sv
// Bench for score_bcd_feeder: directed scenarios plus random scores, every cycle
// compared against a transaction-timed reference model.
module tb_score_bcd_feeder;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [13:0] score_i;
    logic        score_vld_i;
    logic        game_over_i;
    logic [31:0] hexs_o;
    logic [7:0]  point_o;
    logic [7:0]  les_o;
    logic        flash_o;
    logic        start_o;
    logic        busy_o;

    score_bcd_feeder #(
        .BLINK_DIV  (4),
        .REFRESH_DIV(8),
        .LES_MASK   (8'h0F),
        .POINT_MASK (8'hFF)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .score_i    (score_i),
        .score_vld_i(score_vld_i),
        .game_over_i(game_over_i),
        .hexs_o     (hexs_o),
        .point_o    (point_o),
        .les_o      (les_o),
        .flash_o    (flash_o),
        .start_o    (start_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    int n_start  = 0;
    logic prev_start = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a conversion occupies 30 edges after capture; the display
    // word changes on the 29th and Start fires on the 30th.
    int          m_phase, m_idle, m_blink, m_pend_val, m_best;
    bit          m_pend, m_start;
    logic [31:0] m_hexs, m_tgt;

    function automatic int clampv(input int x);
        return (x > 9999) ? 9999 : x;
    endfunction

    function automatic logic [15:0] bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_idle = 0; m_blink = 0; m_pend_val = 0; m_best = 0;
        m_pend = 0; m_start = 0; m_hexs = '0; m_tgt = '0;
    endtask

    task automatic model_edge(input bit vld, input int sc, input bit go);
        int v;
        m_start = 0;
        if (m_phase == 0) begin
            if (vld || m_pend) begin
                v = vld ? clampv(sc) : m_pend_val;
                m_pend = 0;
                if (v > m_best) m_best = v;
                m_tgt = {bcd(m_best), bcd(v)};
                m_phase = 1;
                m_idle = 0;
            end else if (m_idle == 7) begin
                m_start = 1;
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end else begin
            if (vld) begin
                m_pend = 1;
                m_pend_val = clampv(sc);
            end
            if (m_phase == 29) m_hexs = m_tgt;
            if (m_phase == 30) begin
                m_start = 1;
                m_phase = 0;
            end else begin
                m_phase++;
            end
        end
        if (go) m_blink++;
        else m_blink = 0;
    endtask

    task automatic check_all();
        chk("hexs", hexs_o, m_hexs);
        chk("start", 32'(start_o), 32'(m_start));
        chk("busy", 32'(busy_o), 32'(m_phase != 0));
        chk("flash", 32'(flash_o), 32'((m_blink / 4) % 2));
        chk("les", 32'(les_o), (m_blink > 0) ? 32'h0F : 32'h00);
        chk("point", 32'(point_o), 32'hFF);
        chk("start_twice", 32'(start_o & prev_start), 32'd0);
        prev_start = start_o;
        if (start_o) n_start++;
    endtask

    task automatic cycle(input bit vld, input int sc, input bit go);
        score_vld_i = vld;
        score_i     = sc[13:0];
        game_over_i = go;
        @(posedge clk_i);
        model_edge(vld, sc, go);
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input bit go);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, go);
    endtask

    // Called just after an edge; releases reset well before the next one.
    task automatic do_reset();
        score_vld_i = 1'b0;
        game_over_i = 1'b0;
        rst_n_i = 1'b0;
        model_reset();
        #1;
        check_all();
        #2;
        rst_n_i = 1'b1;
    endtask

    initial begin
        int edge_vals[5];
        int sc;
        bit go;
        edge_vals = '{0, 9998, 9999, 10000, 16383};
        rst_n_i = 1'b0;
        score_i = '0;
        score_vld_i = 1'b0;
        game_over_i = 1'b0;
        model_reset();
        #2;
        check_all();
        rst_n_i = 1'b1;

        cycle(1'b1, 1234, 1'b0);
        idle(35, 1'b0);
        chk("hexs_1234", hexs_o, 32'h12341234);
        cycle(1'b1, 56, 1'b0);
        idle(35, 1'b0);
        chk("hexs_56", hexs_o, 32'h12340056);
        cycle(1'b1, 2000, 1'b0);
        idle(35, 1'b0);
        chk("hexs_2000", hexs_o, 32'h20002000);
        cycle(1'b1, 12000, 1'b0);
        idle(35, 1'b0);
        chk("hexs_clamp", hexs_o, 32'h99999999);

        idle(20, 1'b1);
        idle(3, 1'b0);

        idle(8, 1'b0);
        n_start = 0;
        idle(24, 1'b0);
        chk("refresh_cnt", 32'(n_start), 32'd3);
        chk("refresh_hexs", hexs_o, 32'h99999999);

        do_reset();
        n_start = 0;
        cycle(1'b1, 10, 1'b0);
        idle(2, 1'b0);
        cycle(1'b1, 20, 1'b0);
        idle(6, 1'b0);
        cycle(1'b1, 30, 1'b0);
        idle(55, 1'b0);
        chk("pend_hexs", hexs_o, 32'h00300030);
        chk("pend_starts", 32'(n_start), 32'd2);

        cycle(1'b1, 777, 1'b0);
        idle(10, 1'b0);
        do_reset();
        chk("rst_hexs", hexs_o, 32'h0);
        n_start = 0;
        idle(6, 1'b0);
        chk("rst_no_start", 32'(n_start), 32'd0);

        do_reset();
        cycle(1'b1, 4321, 1'b0);
        idle(35, 1'b0);
        chk("first_cycle_vld", hexs_o, 32'h43214321);

        go = 1'b0;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 39) == 0) go = ~go;
            sc = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)]
                                             : int'($urandom_range(0, 16383));
            cycle($urandom_range(0, 11) == 0, sc, go);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
